alu_sequencer: RTL

- Multi-cycle initiator that drives the 8-bit combinational ALU: it produces ALUOp and the A/B operands, and consumes Out and CarryOut.
- Executes macro commands (ADD, SUB, MUL, SHLN) by issuing ALU op sequences and looping on the ALU zero-test.
- Sits between the datapath control and the ALU.
- Command in and result out use valid/ready handshakes.

---
 rtl/alu_sequencer_pkg.sv | 30 +++
 rtl/alu_seq_ovf.sv | 29 ++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: ALU opcodes, command and state encodings.
package alu_sequencer_pkg;

    typedef logic [3:0] alu_op_t;

    // Opcodes understood by the 8-bit combinational ALU
    localparam alu_op_t kCLEAR      = 4'h0;
    localparam alu_op_t kADD        = 4'h1;
    localparam alu_op_t kSUB        = 4'h2;
    localparam alu_op_t kA_IS_ZERO  = 4'h3;
    localparam alu_op_t kSHIFT_LEFT = 4'h4;
    localparam alu_op_t kDEC_A      = 4'h5;

    typedef enum logic [1:0] {
        CMD_ADD  = 2'd0,
        CMD_SUB  = 2'd1,
        CMD_MUL  = 2'd2,
        CMD_SHLN = 2'd3
    } seq_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_TEST = 3'd2,
        ST_BODY = 3'd3,
        ST_DEC  = 3'd4,
        ST_DONE = 3'd5
    } seq_state_e;

endpackage

// File: rtl/alu_seq_ovf.sv
// Overflow detector: flags the cycle in which the current ALU op wraps
// or shifts a set bit out. The top keeps the sticky copy.
module alu_seq_ovf
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  seq_state_e        state_i,
    input  seq_cmd_e          cmd_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] alu_out_i,
    output logic              set_o
);

    // Only EXEC and BODY issue arithmetic that can overflow
    always_comb begin
        set_o = 1'b0;
        if (state_i == ST_EXEC) begin
            if (cmd_i == CMD_SUB) set_o = (a_i < b_i);
            else                  set_o = (alu_out_i < a_i);
        end else if (state_i == ST_BODY) begin
            if (cmd_i == CMD_SHLN) set_o = acc_i[DATA_W-1];
            else                   set_o = (alu_out_i < acc_i);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: runs ADD/SUB/MUL/SHLN macro commands on an
// external combinational ALU, looping on the ALU zero-test.
// Optional overflow flag enabled by defining ALU_SEQ_OVF_EN.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_ovf,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry
);

    seq_state_e        state_q;
    seq_cmd_e          op_q;
    logic [DATA_W-1:0] a_q, b_q, acc_q, cnt_q, mcand_q, res_q;
    seq_cmd_e          cmd_in;
    logic              accept;

    assign cmd_in    = seq_cmd_e'(cmd_op[1:0]);
    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_q;

    // Control FSM: command latch, loop counter, accumulator and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= CMD_ADD;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mcand_q <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q <= cmd_in;
                        case (cmd_in)
                            CMD_MUL: begin
                                mcand_q <= cmd_a;
                                acc_q   <= '0;
                                cnt_q   <= cmd_b;
                                state_q <= ST_TEST;
                            end
                            CMD_SHLN: begin
                                acc_q   <= cmd_a;
                                cnt_q   <= cmd_b;
                                state_q <= ST_TEST;
                            end
                            default: begin
                                a_q     <= cmd_a;
                                b_q     <= cmd_b;
                                state_q <= ST_EXEC;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    res_q   <= alu_out;
                    state_q <= ST_DONE;
                end
                ST_TEST: begin
                    if (alu_carry) begin
                        res_q   <= acc_q;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    acc_q   <= alu_out;
                    state_q <= ST_DEC;
                end
                ST_DEC: begin
                    cnt_q   <= alu_out;
                    state_q <= ST_TEST;
                end
                ST_DONE: begin
                    if (res_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ALU drive decoded from state; idle/done park the ALU on kCLEAR
    always_comb begin
        alu_op = kCLEAR;
        alu_a  = '0;
        alu_b  = '0;
        case (state_q)
            ST_EXEC: begin
                alu_op = (op_q == CMD_SUB) ? kSUB : kADD;
                alu_a  = a_q;
                alu_b  = b_q;
            end
            ST_TEST: begin
                alu_op = kA_IS_ZERO;
                alu_a  = cnt_q;
            end
            ST_BODY: begin
                if (op_q == CMD_SHLN) begin
                    alu_op = kSHIFT_LEFT;
                    alu_a  = acc_q;
                end else begin
                    alu_op = kADD;
                    alu_a  = acc_q;
                    alu_b  = mcand_q;
                end
            end
            ST_DEC: begin
                alu_op = kDEC_A;
                alu_a  = cnt_q;
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_set;
    logic ovf_q;

    alu_seq_ovf #(.DATA_W(DATA_W)) u_ovf (
        .state_i   (state_q),
        .cmd_i     (op_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .acc_i     (acc_q),
        .alu_out_i (alu_out),
        .set_o     (ovf_set)
    );

    // Sticky overflow: cleared on accept, accumulates over the command
    always_ff @(posedge clk) begin
        if (!rst_n)       ovf_q <= 1'b0;
        else if (accept)  ovf_q <= 1'b0;
        else if (ovf_set) ovf_q <= 1'b1;
    end

    assign res_ovf = ovf_q;
`else
    assign res_ovf = 1'b0;
`endif

endmodule
